// File: rtl/isqrt_arb_pkg.sv
// Shared types and defaults for the isqrt round-robin arbiter.
// Requester IDs travel through the tag FIFO as req_id_t.
package isqrt_arb_pkg;

  localparam int N_REQ_DEFAULT     = 3;
  localparam int MAX_OUTST_DEFAULT = 16;

  typedef logic [$clog2(N_REQ_DEFAULT)-1:0] req_id_t;

endpackage

// File: rtl/isqrt_tag_fifo.sv
// Show-ahead tag FIFO holding the requester ID of each in-flight isqrt op.
// Push while full and pop while empty are ignored.
module isqrt_tag_fifo
  import isqrt_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DEFAULT,
  parameter int W_ID  = $bits(req_id_t)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W_ID-1:0] din,
  output logic [W_ID-1:0] head,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W_ID-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  // tag storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin share of one pipelined isqrt among N_REQ requesters.
// Grant counters exist only when ISQRT_ARB_STATS_EN is defined.
module isqrt_rr_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int MAX_OUTST = MAX_OUTST_DEFAULT,
  parameter int W_X       = 32,
  parameter int W_Y       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_x_vld,
  input  logic [W_X-1:0]   req_x [N_REQ],
  output logic [N_REQ-1:0] req_x_rdy,
  output logic [N_REQ-1:0] rsp_y_vld,
  output logic [W_Y-1:0]   rsp_y,
  output logic             isqrt_x_vld,
  output logic [W_X-1:0]   isqrt_x,
  input  logic             isqrt_y_vld,
  input  logic [W_Y-1:0]   isqrt_y,
  input  logic [2:0]       stat_sel,
  output logic [15:0]      stat_cnt
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDW-1:0] prio_ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] head;
  logic           found;
  logic           issue;
  logic           pop;
  logic           full;
  logic           empty;
  int             idx;

  // first valid requester at or after prio_ptr, wrapping
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(prio_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IDW'(idx);
      if (!found && req_x_vld[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // ready is withheld whenever full, even on a pop cycle
  assign issue       = found & ~full;
  assign pop         = isqrt_y_vld & ~empty;
  assign isqrt_x_vld = issue;
  assign rsp_y       = isqrt_y;

  // per-requester handshakes and the issue mux
  always_comb begin
    req_x_rdy = '0;
    rsp_y_vld = '0;
    isqrt_x   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_x_rdy[i] = issue && (winner == IDW'(i));
      rsp_y_vld[i] = pop && (head == IDW'(i));
    end
    if (issue) isqrt_x = req_x[winner];
  end

  // priority moves just past the last winner
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr <= '0;
    end else if (issue) begin
      if (winner == IDW'(N_REQ-1)) prio_ptr <= '0;
      else prio_ptr <= winner + IDW'(1);
    end
  end

  isqrt_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .W_ID  (IDW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (pop),
    .din   (winner),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef ISQRT_ARB_STATS_EN
  logic [15:0] cnt [N_REQ];

  // saturating grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else if (issue && cnt[winner] != 16'hFFFF) begin
      cnt[winner] <= cnt[winner] + 16'd1;
    end
  end

  // out-of-range selects read zero
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (stat_sel == 3'(i)) stat_cnt = cnt[i];
    end
  end
`else
  logic [2:0] stat_unused;
  assign stat_unused = stat_sel;
  assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Bench for isqrt_rr_arbiter: isqrt latency model, scoreboard,
// grant table, and hand sequences for stall, reset and stats.
module tb_isqrt_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_x_vld = '0;
  logic [31:0] req_x [3];
  logic [2:0]  req_x_rdy;
  logic [2:0]  rsp_y_vld;
  logic [15:0] rsp_y;
  logic        isqrt_x_vld;
  logic [31:0] isqrt_x;
  logic        isqrt_y_vld = 1'b0;
  logic [15:0] isqrt_y = '0;
  logic [2:0]  stat_sel = '0;
  logic [15:0] stat_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  isqrt_rr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_x_vld   (req_x_vld),
    .req_x       (req_x),
    .req_x_rdy   (req_x_rdy),
    .rsp_y_vld   (rsp_y_vld),
    .rsp_y       (rsp_y),
    .isqrt_x_vld (isqrt_x_vld),
    .isqrt_x     (isqrt_x),
    .isqrt_y_vld (isqrt_y_vld),
    .isqrt_y     (isqrt_y),
    .stat_sel    (stat_sel),
    .stat_cnt    (stat_cnt)
  );

  function automatic logic [15:0] isqrt_f(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'h1 << b);
      if (32'(t) * 32'(t) <= x) r = t;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // isqrt model: fixed latency, ignores rst so stale pulses appear
  typedef struct {int due; logic [15:0] y;} mp_t;
  mp_t mq[$];
  int  lat = 1;
  int  cyc = 0;

  always @(negedge clk) begin
    if (!rst && isqrt_x_vld)
      mq.push_back('{cyc + lat, isqrt_f(isqrt_x)});
  end

  always @(posedge clk) begin
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      isqrt_y_vld <= 1'b1;
      isqrt_y     <= mq[0].y;
      void'(mq.pop_front());
    end else begin
      isqrt_y_vld <= 1'b0;
    end
  end

  // scoreboard monitor
  typedef struct {int id; logic [15:0] y;} ent_t;
  ent_t exp_q[$];
  ent_t rsp_log[$];
  int   glog[$];

  always @(negedge clk) begin
    ent_t e;
    int   id;
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("fifo_count", 32'(dut.u_fifo.count), exp_q.size());
      chk("rdy_no_vld", 32'(req_x_rdy & ~req_x_vld), 0);
      chk("x_vld", 32'(isqrt_x_vld), 32'(|(req_x_rdy & req_x_vld)));
      if (isqrt_y_vld || |rsp_y_vld) begin
        if (exp_q.size() == 0) begin
          chk("drop", 32'(rsp_y_vld), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_vld", 32'(rsp_y_vld), 32'(1 << e.id));
          chk("rsp_y", 32'(rsp_y), 32'(e.y));
          id = -1;
          for (int i = 0; i < 3; i++) if (rsp_y_vld[i]) id = i;
          rsp_log.push_back('{id, rsp_y});
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (req_x_vld[i] && req_x_rdy[i]) begin
          exp_q.push_back('{i, isqrt_f(req_x[i])});
          glog.push_back(i);
          chk("pass_x", isqrt_x, req_x[i]);
        end
      end
    end
  end

  task automatic run(input logic [2:0] vld, input int n);
    int k [3];
    for (int i = 0; i < 3; i++) k[i] = 0;
    for (int c = 0; c < n; c++) begin
      req_x_vld = vld;
      for (int i = 0; i < 3; i++) req_x[i] = 32'(i * 100 + k[i]);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (req_x_vld[i] && req_x_rdy[i]) k[i]++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    req_x_vld = '0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (mq.size() == 0 && exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size() + mq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_x_vld = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {logic [2:0] vld; logic [2:0] rdy;} gv_t;
  typedef struct {logic [31:0] x; logic [15:0] y;} sv_t;

  initial begin
    gv_t gt [8];
    sv_t st [3];
    int  gc [3];
    int  npp;

    gt[0] = '{3'b111, 3'b001};
    gt[1] = '{3'b111, 3'b010};
    gt[2] = '{3'b101, 3'b100};
    gt[3] = '{3'b110, 3'b010};
    gt[4] = '{3'b011, 3'b001};
    gt[5] = '{3'b000, 3'b000};
    gt[6] = '{3'b001, 3'b001};
    gt[7] = '{3'b100, 3'b100};
    st[0] = '{32'd16, 16'd4};
    st[1] = '{32'd81, 16'd9};
    st[2] = '{32'd1000, 16'd31};
    for (int i = 0; i < 3; i++) req_x[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(req_x_rdy), 0);
    chk("rst_rsp", 32'(rsp_y_vld), 0);
    chk("rst_xvld", 32'(isqrt_x_vld), 0);
    chk("rst_stat", 32'(stat_cnt), 0);
    @(posedge clk);
    #1;

    // round-robin grant table
    lat = 1;
    for (int j = 0; j < 8; j++) begin
      req_x_vld = gt[j].vld;
      for (int i = 0; i < 3; i++) req_x[i] = 32'(i * 100 + j);
      @(negedge clk);
      chk("grant_rdy", 32'(req_x_rdy), 32'(gt[j].rdy));
      chk("grant_xvld", 32'(isqrt_x_vld), 32'(|gt[j].vld));
      @(posedge clk);
      #1;
    end
    drain();

    // fairness, all valid for 300 cycles
    glog.delete();
    run(3'b111, 300);
    drain();
    chk("fair_len", glog.size(), 300);
    for (int j = 0; j < 6; j++) chk("fair_order", glog[j], j % 3);
    for (int i = 0; i < 3; i++) gc[i] = 0;
    foreach (glog[j]) gc[glog[j]]++;
    for (int i = 0; i < 3; i++) chk("fair_cnt", gc[i], 100);
`ifndef ISQRT_ARB_STATS_EN
    for (int i = 0; i < 3; i++) begin
      stat_sel = 3'(i);
      #1;
      chk("stat_off", 32'(stat_cnt), 0);
    end
`endif

    // single requester, back-to-back
    rsp_log.delete();
    for (int j = 0; j < 3; j++) begin
      req_x_vld = 3'b010;
      req_x[1]  = st[j].x;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    drain();
    chk("single_n", rsp_log.size(), 3);
    for (int j = 0; j < 3 && j < rsp_log.size(); j++) begin
      chk("single_id", rsp_log[j].id, 1);
      chk("single_y", 32'(rsp_log[j].y), 32'(st[j].y));
    end

    // stall: latency beyond FIFO depth
    lat = 40;
    glog.delete();
    run(3'b001, 30);
    chk("stall_issues", glog.size(), 16);
    @(negedge clk);
    chk("stall_rdy", 32'(req_x_rdy), 0);
    for (int t = 0; t < 60; t++) begin
      if (|rsp_y_vld) break;
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    chk("stall_rsp", 32'(rsp_y_vld), 1);
    chk("full_pop_rdy", 32'(req_x_rdy), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("resume_rdy", 32'(req_x_rdy), 1);
    @(posedge clk);
    #1;
    drain();

    // simultaneous push and pop at count 5
    lat = 5;
    npp = 0;
    req_x_vld = 3'b100;
    for (int c = 0; c < 20; c++) begin
      req_x[2] = 32'(500 + c);
      @(negedge clk);
      if (isqrt_x_vld && |rsp_y_vld) begin
        npp++;
        chk("pp_count", 32'(dut.u_fifo.count), 5);
        chk("pp_route", 32'(rsp_y_vld), 32'b100);
      end
      @(posedge clk);
      #1;
    end
    chk("pp_seen", 32'(npp >= 10), 1);
    drain();

    // mid-operation reset with 4 in flight
    lat = 10;
    run(3'b111, 4);
    rst = 1'b1;
    req_x_vld = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      chk("post_rst_rsp", 32'(rsp_y_vld), 0);
      @(posedge clk);
      #1;
    end
    drain();
    req_x_vld = 3'b101;
    req_x[0]  = 32'd49;
    req_x[2]  = 32'd64;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_x_rdy), 32'b001);
    @(posedge clk);
    #1;
    drain();

`ifdef ISQRT_ARB_STATS_EN
    lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      stat_sel = 3'(i);
      #1;
      chk("stat_clr", 32'(stat_cnt), 0);
    end
    run(3'b100, 1000);
    stat_sel = 3'd2;
    #1;
    chk("stat_1000", 32'(stat_cnt), 1000);
    run(3'b100, 69000);
    drain();
    stat_sel = 3'd2;
    #1;
    chk("stat_sat", 32'(stat_cnt), 32'hFFFF);
    stat_sel = 3'd0;
    #1;
    chk("stat_other", 32'(stat_cnt), 0);
    stat_sel = 3'd5;
    #1;
    chk("stat_range", 32'(stat_cnt), 0);
`else
    stat_sel = 3'd2;
    #1;
    chk("stat_off_end", 32'(stat_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
